// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the I/D memory port arbiter:
// requester IDs and memory transfer-size codes.
package mem_port_arbiter_pkg;

  localparam int MEM_XFER_W = 2;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [MEM_XFER_W-1:0] XFER_BYTE = 2'b00;
  localparam logic [MEM_XFER_W-1:0] XFER_HALF = 2'b01;
  localparam logic [MEM_XFER_W-1:0] XFER_WORD = 2'b10;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order ID FIFO: circular buffer, pointers carry one extra MSB
// so full and empty are distinguishable.
// Ports: clk, rst, push_i, pop_i, din_i, dout_o, full_o, empty_o.
module arb_id_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_MSB = PW'(1) << (PW - 1);

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [W-1:0]  mem_q [2**AW];
  logic [AW-1:0] wi, ri;

  // Index is the pointer modulo DEPTH; a single-entry FIFO uses slot 0.
  assign wi = (DEPTH > 1) ? AW'(wr_q) : '0;
  assign ri = (DEPTH > 1) ? AW'(rd_q) : '0;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = ((wr_q ^ rd_q) == PTR_MSB);
  assign dout_o  = mem_q[ri];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i && !full_o) wr_d = wr_q + PW'(1);
    if (pop_i && !empty_o) rd_d = rd_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wi] <= din_i;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (I) and
// load/store (D); responses steered back via an in-order ID FIFO.
// Ports: i_* fetch side, d_* data side, mem_* memory side, err_o sticky.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int XFER_W    = MEM_XFER_W,
  parameter int MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic              d_wr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [XFER_W-1:0] d_xfer_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [XFER_W-1:0] mem_xfer_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  logic lock_q, lock_d;
  logic sel_q, sel_d;
  logic rr_last_q, rr_last_d;
  logic err_q, err_d;
  logic sel, sel_req, hs, pop;
  logic full, empty, head;

  arb_id_fifo #(
    .W     (1),
    .DEPTH (MAX_OUTST)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (hs),
    .pop_i   (pop),
    .din_i   (sel),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    sel = PORT_I;
    if (lock_q)                sel = sel_q;
    else if (i_req_i && d_req_i) sel = ~rr_last_q;
    else if (d_req_i)          sel = PORT_D;
    sel_req = (sel == PORT_D) ? d_req_i : i_req_i;
  end

  // Everything on the outward side is forced quiet while rst is held,
  // independent of clock, since the request path is combinational.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wr_o    = 1'b0;
    mem_wdata_o = '0;
    mem_xfer_o  = '0;
    if (!rst) begin
      mem_req_o = sel_req & ~full;
      if (sel == PORT_D) begin
        mem_addr_o  = d_addr_i;
        mem_wr_o    = d_wr_i;
        mem_wdata_o = d_wdata_i;
        mem_xfer_o  = d_xfer_i;
      end else begin
        mem_addr_o = i_addr_i;
        mem_xfer_o = XFER_W'(XFER_WORD);
      end
    end
  end

  assign hs      = mem_req_o & mem_gnt_i;
  assign i_gnt_o = hs & (sel == PORT_I);
  assign d_gnt_o = hs & (sel == PORT_D);

  assign pop        = mem_rvalid_i & ~empty & ~rst;
  assign i_rvalid_o = pop & (head == PORT_I);
  assign d_rvalid_o = pop & (head == PORT_D);
  assign i_rdata_o  = mem_rdata_i;
  assign d_rdata_o  = mem_rdata_i;
  assign err_o      = err_q;

  always_comb begin
    lock_d    = lock_q;
    sel_d     = sel_q;
    rr_last_d = rr_last_q;
    err_d     = err_q | (mem_rvalid_i & empty);
    if (hs) begin
      lock_d    = 1'b0;
      rr_last_d = sel;
    end else if (mem_req_o) begin
      lock_d = 1'b1;
      sel_d  = sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q    <= 1'b0;
      sel_q     <= PORT_I;
      rr_last_q <= PORT_D;
      err_q     <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      sel_q     <= sel_d;
      rr_last_q <= rr_last_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a
// queue-based reference model of the arbitration and response rules.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int XW = 2;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_wr, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [XW-1:0] d_xfer;
  logic          mem_req, mem_wr, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [XW-1:0] mem_xfer;
  logic          err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .XFER_W    (XW),
    .MAX_OUTST (MO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_i      (i_req),
    .i_addr_i     (i_addr),
    .i_gnt_o      (i_gnt),
    .i_rvalid_o   (i_rvalid),
    .i_rdata_o    (i_rdata),
    .d_req_i      (d_req),
    .d_addr_i     (d_addr),
    .d_wr_i       (d_wr),
    .d_wdata_i    (d_wdata),
    .d_xfer_i     (d_xfer),
    .d_gnt_o      (d_gnt),
    .d_rvalid_o   (d_rvalid),
    .d_rdata_o    (d_rdata),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_wr_o     (mem_wr),
    .mem_wdata_o  (mem_wdata),
    .mem_xfer_o   (mem_xfer),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .err_o        (err)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: outstanding port IDs in issue order, the port
  // currently waiting for a grant, last granted port, sticky error.
  bit q[$];
  bit held, held_port, last, m_err;

  task automatic model_reset();
    q.delete();
    held      = 0;
    held_port = 0;
    last      = 1;
    m_err     = 0;
  endtask

  task automatic step(output bit ig, output bit dg);
    bit sel, sreq, full, ereq, hs, rv_ok, head;
    #1;
    full = (q.size() == MO);
    if (held)                sel = held_port;
    else if (i_req && d_req) sel = !last;
    else                     sel = d_req;
    sreq  = sel ? d_req : i_req;
    ereq  = sreq && !full;
    hs    = ereq && mem_gnt;
    ig    = hs && !sel;
    dg    = hs && sel;
    rv_ok = mem_rvalid && (q.size() > 0);
    head  = rv_ok ? q[0] : 1'b0;
    chk("mem_req", 64'(mem_req), 64'(ereq));
    chk("i_gnt", 64'(i_gnt), 64'(ig));
    chk("d_gnt", 64'(d_gnt), 64'(dg));
    if (ereq) begin
      chk("mem_addr", 64'(mem_addr), 64'(sel ? d_addr : i_addr));
      chk("mem_wr", 64'(mem_wr), 64'(sel ? d_wr : 1'b0));
      chk("mem_wdata", 64'(mem_wdata), 64'(sel ? d_wdata : 32'h0));
      chk("mem_xfer", 64'(mem_xfer), 64'(sel ? d_xfer : 2'b10));
    end
    chk("i_rvalid", 64'(i_rvalid), 64'(rv_ok && !head));
    chk("d_rvalid", 64'(d_rvalid), 64'(rv_ok && head));
    if (rv_ok)
      chk("rdata", 64'(head ? d_rdata : i_rdata), 64'(mem_rdata));
    chk("err", 64'(err), 64'(m_err));
    @(posedge clk);
    if (rv_ok) void'(q.pop_front());
    else if (mem_rvalid) m_err = 1;
    if (hs) begin
      q.push_back(sel);
      last = sel;
      held = 0;
    end else if (ereq) begin
      held      = 1;
      held_port = sel;
    end
  endtask

  task automatic idle_inputs();
    i_req      = 0;
    i_addr     = '0;
    d_req      = 0;
    d_addr     = '0;
    d_wr       = 0;
    d_wdata    = '0;
    d_xfer     = '0;
    mem_gnt    = 0;
    mem_rvalid = 0;
    mem_rdata  = '0;
  endtask

  initial begin
    bit ig, dg, ip, dp;
    idle_inputs();
    model_reset();
    rst        = 1;
    i_req      = 1;
    d_req      = 1;
    i_addr     = 32'h40;
    mem_gnt    = 1;
    mem_rvalid = 1;
    #12;
    chk("rst_mem_req", 64'(mem_req), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_i_gnt", 64'(i_gnt), 0);
    chk("rst_d_gnt", 64'(d_gnt), 0);
    chk("rst_i_rvalid", 64'(i_rvalid), 0);
    chk("rst_d_rvalid", 64'(d_rvalid), 0);
    chk("rst_err", 64'(err), 0);
    @(negedge clk);
    rst = 0;
    idle_inputs();

    // single fetch, response two cycles after grant
    i_req   = 1;
    i_addr  = 32'h100;
    mem_gnt = 1;
    step(ig, dg);
    chk("fetch_gnt", 64'(ig), 1);
    @(negedge clk);
    idle_inputs();
    step(ig, dg);
    @(negedge clk);
    mem_rvalid = 1;
    mem_rdata  = 32'hDEADBEEF;
    step(ig, dg);
    chk("fetch_rdata", 64'(i_rdata), 64'(32'hDEADBEEF));

    // randomized traffic: contention, backpressure, full FIFO
    ip = 0;
    dp = 0;
    ig = 0;
    dg = 0;
    repeat (3000) begin
      @(negedge clk);
      if (ig) begin ip = 0; i_req = 0; end
      if (dg) begin dp = 0; d_req = 0; end
      if (!ip && ($urandom % 3 == 0)) begin
        ip     = 1;
        i_req  = 1;
        i_addr = $urandom;
      end
      if (!dp && ($urandom % 3 == 0)) begin
        dp      = 1;
        d_req   = 1;
        d_addr  = $urandom;
        d_wr    = 1'($urandom);
        d_wdata = $urandom;
        d_xfer  = 2'($urandom_range(2));
      end
      mem_gnt    = ($urandom % 4) != 0;
      mem_rvalid = (q.size() > 0) && ($urandom % 3 == 0);
      mem_rdata  = $urandom;
      step(ig, dg);
    end

    // drain, then a spurious response with nothing outstanding
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ig) begin ip = 0; i_req = 0; end
      if (dg) begin dp = 0; d_req = 0; end
      mem_gnt    = !(ip || dp) ? 1'b0 : 1'b1;
      mem_rvalid = q.size() > 0;
      step(ig, dg);
    end
    chk("drained", 64'(q.size()), 0);
    @(negedge clk);
    idle_inputs();
    mem_rvalid = 1;
    step(ig, dg);
    @(negedge clk);
    mem_rvalid = 0;
    step(ig, dg);
    repeat (3) @(negedge clk);
    chk("err_sticky", 64'(err), 1);

    // async reset with one transaction outstanding
    @(negedge clk);
    rst = 1;
    #3;
    rst = 0;
    model_reset();
    @(negedge clk);
    i_req   = 1;
    i_addr  = 32'h300;
    mem_gnt = 1;
    step(ig, dg);
    @(negedge clk);
    i_addr = 32'h304;
    #2;
    rst = 1;
    #1;
    chk("arst_mem_req", 64'(mem_req), 0);
    chk("arst_i_gnt", 64'(i_gnt), 0);
    chk("arst_mem_addr", 64'(mem_addr), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    idle_inputs();
    mem_rvalid = 1;
    step(ig, dg);
    @(negedge clk);
    idle_inputs();
    i_req   = 1;
    i_addr  = 32'h500;
    mem_gnt = 1;
    step(ig, dg);
    chk("post_rst_gnt", 64'(ig), 1);
    @(negedge clk);
    idle_inputs();
    mem_rvalid = 1;
    mem_rdata  = 32'h1234;
    step(ig, dg);
    @(negedge clk);
    idle_inputs();
    step(ig, dg);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
